// File: rtl/fir_mac_accumulator_pkg.sv
// Shared definitions for the time-multiplexed FIR MAC stage.
// Q-format widths here are also used by the downstream shrink stage.
package fir_mac_accumulator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   localparam int DIN_W  = 24;
   localparam int COEF_W = 20;
   localparam int TAPS_N = 8;
   localparam int ACC_W  = 47;

   function automatic int acc_min(input int d, input int c, input int t);
      return d + c + $clog2(t);
   endfunction

endpackage

// File: rtl/fir_mac_accumulator_mult.sv
// Registered signed multiplier, one cycle latency.
// Kept separate so it maps cleanly onto a DSP block.
module fir_mac_accumulator_mult #(
   parameter int A_WIDTH = 24,
   parameter int B_WIDTH = 20
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic signed [A_WIDTH-1:0]         a,
   input  logic signed [B_WIDTH-1:0]         b,
   output logic signed [A_WIDTH+B_WIDTH-1:0] p,
   output logic                              p_valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p       <= '0;
         p_valid <= 1'b0;
      end else begin
         p_valid <= en;
         if (en) p <= a * b;
      end
   end

endmodule

// File: rtl/fir_mac_accumulator.sv
// Time-multiplexed signed FIR: one multiplier, TAPS MAC cycles per sample,
// full-precision accumulator output with valid/ready handshakes.
module fir_mac_accumulator
   import fir_mac_accumulator_pkg::*;
#(
   parameter int DIN_WIDTH  = DIN_W,
   parameter int COEF_WIDTH = COEF_W,
   parameter int TAPS       = TAPS_N,
   parameter int ACC_WIDTH  = ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DIN_WIDTH-1:0]    in_data,
   input  logic                    coef_we,
   input  logic [$clog2(TAPS)-1:0] coef_addr,
   input  logic [COEF_WIDTH-1:0]   coef_data,
   output logic                    coef_wr_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_WIDTH-1:0]    out_data,
   output logic                    busy
);

   localparam int AW = $clog2(TAPS);
   localparam int PW = DIN_WIDTH + COEF_WIDTH;
   localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

   if (ACC_WIDTH < acc_min(DIN_WIDTH, COEF_WIDTH, TAPS)) begin : g_bad_acc
      $error("ACC_WIDTH too small for lossless accumulation");
   end
   if (TAPS < 2 || (TAPS & (TAPS - 1)) != 0) begin : g_bad_taps
      $error("TAPS must be a power of 2 and >= 2");
   end

   state_t                       state;
   logic [AW-1:0]                wr_ptr;
   logic [AW-1:0]                k;
   logic [AW-1:0]                rd_idx;
   logic signed [DIN_WIDTH-1:0]  dline [TAPS];
   logic signed [COEF_WIDTH-1:0] coef  [TAPS];
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [PW-1:0]         prod;
   logic                         prod_vld;
   logic                         issue;

   // wr_ptr already points past the newest sample while in MAC
   assign rd_idx    = wr_ptr - AW'(1) - k;
   assign issue     = (state == ST_MAC);
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_OUT);
   assign busy      = (state != ST_IDLE);
   assign out_data  = acc;

   fir_mac_accumulator_mult #(
      .A_WIDTH (DIN_WIDTH),
      .B_WIDTH (COEF_WIDTH)
   ) u_mult (
      .clk     (clk),
      .rst     (rst),
      .en      (issue),
      .a       (dline[rd_idx]),
      .b       (coef[k]),
      .p       (prod),
      .p_valid (prod_vld)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         wr_ptr      <= '0;
         k           <= '0;
         acc         <= '0;
         coef_wr_err <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            dline[i] <= '0;
            coef[i]  <= '0;
         end
      end else begin
         coef_wr_err <= coef_we && (state != ST_IDLE);
         if (prod_vld) acc <= acc + ACC_WIDTH'(prod);
         unique case (state)
            ST_IDLE: begin
               if (coef_we) coef[coef_addr] <= coef_data;
               if (in_valid) begin
                  dline[wr_ptr] <= in_data;
                  wr_ptr        <= wr_ptr + AW'(1);
                  acc           <= '0;
                  k             <= '0;
                  state         <= ST_MAC;
               end
            end
            ST_MAC: begin
               k <= k + AW'(1);
               if (k == K_LAST) state <= ST_DRAIN;
            end
            ST_DRAIN: state <= ST_OUT;
            ST_OUT: if (out_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_accumulator.sv
// Randomized bench for fir_mac_accumulator against a direct-form FIR model.
// Model keeps plain sample history and coefficient arrays in longint.
module tb_fir_mac_accumulator;

   localparam int DW   = 24;
   localparam int CW   = 20;
   localparam int TAPS = 8;
   localparam int ACW  = 47;
   localparam int PER  = TAPS + 3;

   logic            clk = 0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic            coef_we;
   logic [2:0]      coef_addr;
   logic [CW-1:0]   coef_data;
   logic            coef_wr_err;
   logic            out_valid;
   logic            out_ready;
   logic [ACW-1:0]  out_data;
   logic            busy;

   int n_checks = 0;
   int n_pass   = 0;

   longint h    [TAPS];
   longint hist [TAPS];

   fir_mac_accumulator dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_data   (coef_data),
      .coef_wr_err (coef_wr_err),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic void model_clear();
      for (int i = 0; i < TAPS; i++) begin
         h[i]    = 0;
         hist[i] = 0;
      end
   endfunction

   function automatic void model_push(input logic [DW-1:0] x);
      for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = longint'($signed(x));
   endfunction

   function automatic logic [ACW-1:0] model_y();
      longint s = 0;
      for (int i = 0; i < TAPS; i++) s += h[i] * hist[i];
      return ACW'(s);
   endfunction

   task automatic do_reset();
      rst       = 1;
      in_valid  = 0;
      in_data   = '0;
      coef_we   = 0;
      coef_addr = '0;
      coef_data = '0;
      out_ready = 1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_err", coef_wr_err, 0);
      rst = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input int a, input logic [CW-1:0] d);
      coef_we   = 1;
      coef_addr = 3'(a);
      coef_data = d;
      @(posedge clk);
      #1;
      coef_we = 0;
      h[a]    = longint'($signed(d));
   endtask

   task automatic run_sample(input logic [DW-1:0] x, input bit poke,
                             output logic [ACW-1:0] got);
      int lat;
      bit ok = 0;
      logic [ACW-1:0] exp;
      got      = '0;
      in_data  = x;
      in_valid = 1;
      for (int n = 0; n < 40; n++) begin
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      check("accept", ok, 1);
      if (!ok) return;
      model_push(x);
      exp = model_y();
      check("busy_mac", {busy, in_ready}, 2'b10);
      lat = 1;
      if (poke) begin
         coef_we   = 1;
         coef_addr = 0;
         coef_data = 20'h7FFFF;
         @(posedge clk);
         #1;
         lat++;
         coef_we = 0;
         check("wr_err_pulse", coef_wr_err, 1);
         @(posedge clk);
         #1;
         lat++;
         check("wr_err_clear", coef_wr_err, 0);
      end
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, TAPS + 2);
      check("out_data", out_data, exp);
      got = out_data;
      out_ready = 1;
      @(posedge clk);
      #1;
   endtask

   logic [ACW-1:0] y;
   logic [ACW-1:0] held;
   logic [DW-1:0]  xr;
   logic [ACW-1:0] exp_q [$];

   initial begin
      do_reset();

      // impulse response
      for (int i = 0; i < TAPS; i++) write_coef(i, 20'h40000);
      for (int i = 0; i <= TAPS; i++) begin
         run_sample(i == 0 ? 24'h400000 : 24'h0, 0, y);
         check($sformatf("impulse_%0d", i), y,
               i < TAPS ? 47'h0100_0000_0000 : 47'h0);
      end

      // full-scale negative inputs and coefficients
      for (int i = 0; i < TAPS; i++) write_coef(i, 20'h80000);
      for (int i = 0; i < TAPS; i++) run_sample(24'h800000, 0, y);
      check("extreme", y, 47'h2000_0000_0000);

      // random coefficients and samples
      for (int i = 0; i < TAPS; i++) write_coef(i, CW'($urandom));
      for (int i = 0; i < 20; i++) run_sample(DW'($urandom), 0, y);

      // coefficient write while busy is dropped
      run_sample(DW'($urandom), 1, y);
      run_sample(DW'($urandom), 0, y);

      // backpressure in OUT
      out_ready = 0;
      xr = DW'($urandom);
      in_data = xr;
      in_valid = 1;
      @(posedge clk);
      #1;
      in_valid = 0;
      model_push(xr);
      for (int n = 0; n < 40 && !out_valid; n++) begin
         @(posedge clk);
         #1;
      end
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, model_y());
      held = out_data;
      xr = DW'($urandom);
      in_data = xr;
      in_valid = 1;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk);
         #1;
         check("bp_hold", {out_valid, in_ready, out_data}, {2'b10, held});
      end
      out_ready = 1;
      @(posedge clk);
      #1;
      check("bp_release", {out_valid, in_ready, busy}, 3'b010);
      run_sample(xr, 0, y);

      // reset in the middle of MAC
      in_data = DW'($urandom);
      in_valid = 1;
      @(posedge clk);
      #1;
      in_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      model_clear();
      @(posedge clk);
      #1;
      rst = 0;
      @(posedge clk);
      #1;
      write_coef(0, 20'h40000);
      run_sample(24'h400000, 0, y);
      check("midrst_impulse", y, 47'h0100_0000_0000);

      // throughput with both handshakes held
      for (int i = 0; i < TAPS; i++) write_coef(i, CW'($urandom));
      begin
         int cyc = 0;
         int last = -1;
         int accepts = 0;
         bit acc_now;
         bit hs_now;
         logic [ACW-1:0] od;
         out_ready = 1;
         in_data = DW'($urandom);
         in_valid = 1;
         for (int n = 0; n < 130; n++) begin
            if (n == 100) in_valid = 0;
            acc_now = in_valid && in_ready;
            hs_now  = out_valid && out_ready;
            od      = out_data;
            @(posedge clk);
            #1;
            cyc++;
            if (acc_now) begin
               if (last >= 0) check("tp_period", cyc - last, PER);
               last = cyc;
               accepts++;
               model_push(in_data);
               exp_q.push_back(model_y());
               in_data = DW'($urandom);
            end
            if (hs_now) begin
               if (exp_q.size() == 0) check("tp_extra_out", 1, 0);
               else check("tp_data", od, exp_q.pop_front());
            end
         end
         check("tp_accepts", accepts, (100 + PER - 1) / PER);
         check("tp_drained", exp_q.size(), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
